// File: rtl/regfile_if.sv
// Register-file access bundle: one write port and two read ports.
// The master drives the selects and write data; the slave returns read data.
interface regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) ();
   logic [ADDR_W-1:0] wr_num;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;
   logic [ADDR_W-1:0] rd0_num;
   logic [DATA_W-1:0] rd0_data;
   logic [ADDR_W-1:0] rd1_num;
   logic [DATA_W-1:0] rd1_data;

   modport master (
      output wr_num, wr_data, wr_en, rd0_num, rd1_num,
      input  rd0_data, rd1_data
   );

   modport slave (
      input  wr_num, wr_data, wr_en, rd0_num, rd1_num,
      output rd0_data, rd1_data
   );
endinterface

// File: rtl/regfile.sv
// Two-read / one-write register file, 2**ADDR_W entries of DATA_W bits.
// Entry 0 is hardwired to zero. Synchronous active-high reset clears all entries.
// Optional macro REGFILE_BYPASS_EN: a read of the entry being written in the
// same cycle returns the incoming write data instead of the stored value.
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic       clk,
   input logic       reset,
   regfile_if.slave  rf
);
   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic              wr_hit;
   logic [DATA_W-1:0] rd0_val;
   logic [DATA_W-1:0] rd1_val;

   // A write is effective only when enabled and not aimed at entry 0.
   assign wr_hit = rf.wr_en && (rf.wr_num != '0);

   // Next-state of the storage array.
   always_comb begin
      regs_d = regs_q;
      if (wr_hit) begin
         regs_d[rf.wr_num] = rf.wr_data;
      end
      regs_d[0] = '0;
   end

   // Storage update; reset wins over any write in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Combinational read ports, with optional write-through bypass.
   always_comb begin
      rd0_val = regs_q[rf.rd0_num];
      rd1_val = regs_q[rf.rd1_num];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && !reset && (rf.rd0_num == rf.wr_num)) begin
         rd0_val = rf.wr_data;
      end
      if (wr_hit && !reset && (rf.rd1_num == rf.wr_num)) begin
         rd1_val = rf.wr_data;
      end
`endif
      if (rf.rd0_num == '0) begin
         rd0_val = '0;
      end
      if (rf.rd1_num == '0) begin
         rd1_val = '0;
      end
   end

   assign rf.rd0_data = rd0_val;
   assign rf.rd1_data = rd1_val;
endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile (default 32x32 configuration).
module tb_regfile;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf ();

   regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] num, input logic [DATA_W-1:0] data);
      rf.wr_num  = num;
      rf.wr_data = data;
      rf.wr_en   = 1'b1;
      tick();
      rf.wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [ADDR_W-1:0] n0, input logic [ADDR_W-1:0] n1);
      rf.rd0_num = n0;
      rf.rd1_num = n1;
      #1;
   endtask

   logic [DATA_W-1:0] rdw_exp;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      rf.wr_en   = 1'b0;
      rf.wr_num  = '0;
      rf.wr_data = '0;
      rf.rd0_num = '0;
      rf.rd1_num = '0;
      tick();
      reset = 1'b0;

      // All entries read zero after reset, both ports.
      for (int i = 0; i < 32; i++) begin
         rd(ADDR_W'(i), ADDR_W'(31 - i));
         chk($sformatf("reset_rd0_%0d", i), rf.rd0_data, 32'h0);
         chk($sformatf("reset_rd1_%0d", 31 - i), rf.rd1_data, 32'h0);
      end

      // Write / read back.
      wr(5'd29, 32'h8012_0000);
      wr(5'd31, 32'h0000_0000);
      wr(5'd5,  32'hDEAD_BEEF);
      rd(5'd29, 5'd5);
      chk("wb_r29", rf.rd0_data, 32'h8012_0000);
      chk("wb_r5",  rf.rd1_data, 32'hDEAD_BEEF);
      rd(5'd31, 5'd29);
      chk("wb_r31", rf.rd0_data, 32'h0000_0000);
      chk("wb_r29_p1", rf.rd1_data, 32'h8012_0000);

      // Entry 0 ignores writes, including in the write cycle itself.
      rd(5'd0, 5'd0);
      rf.wr_num  = 5'd0;
      rf.wr_data = 32'hFFFF_FFFF;
      rf.wr_en   = 1'b1;
      #1;
      chk("r0_same_cycle", rf.rd0_data, 32'h0);
      tick();
      rf.wr_en = 1'b0;
      rd(5'd0, 5'd0);
      chk("r0_rd0", rf.rd0_data, 32'h0);
      chk("r0_rd1", rf.rd1_data, 32'h0);

      // Write enable low leaves contents untouched.
      wr(5'd7, 32'h1111_1111);
      rf.wr_num  = 5'd7;
      rf.wr_data = 32'h2222_2222;
      rf.wr_en   = 1'b0;
      tick();
      rd(5'd7, 5'd7);
      chk("wen_r7_rd0", rf.rd0_data, 32'h1111_1111);
      chk("wen_r7_rd1", rf.rd1_data, 32'h1111_1111);

      // Read during write on both ports.
`ifdef REGFILE_BYPASS_EN
      rdw_exp = 32'h0000_000B;
`else
      rdw_exp = 32'h0000_000A;
`endif
      wr(5'd3, 32'h0000_000A);
      rd(5'd3, 5'd3);
      rf.wr_num  = 5'd3;
      rf.wr_data = 32'h0000_000B;
      rf.wr_en   = 1'b1;
      #1;
      chk("rdw_same_rd0", rf.rd0_data, rdw_exp);
      chk("rdw_same_rd1", rf.rd1_data, rdw_exp);
      tick();
      rf.wr_en = 1'b0;
      #1;
      chk("rdw_next_rd0", rf.rd0_data, 32'h0000_000B);
      chk("rdw_next_rd1", rf.rd1_data, 32'h0000_000B);

      // Different-register write does not disturb reads of others.
      rd(5'd5, 5'd29);
      rf.wr_num  = 5'd12;
      rf.wr_data = 32'h1234_5678;
      rf.wr_en   = 1'b1;
      #1;
      chk("indep_r5", rf.rd0_data, 32'hDEAD_BEEF);
      chk("indep_r29", rf.rd1_data, 32'h8012_0000);
      tick();
      rf.wr_en = 1'b0;
      rd(5'd12, 5'd3);
      chk("indep_r12", rf.rd0_data, 32'h1234_5678);
      chk("indep_r3", rf.rd1_data, 32'h0000_000B);

      // Reset priority over a write; contents hold until the edge.
      wr(5'd9, 32'h0000_0077);
      rd(5'd9, 5'd5);
      reset      = 1'b1;
      rf.wr_num  = 5'd9;
      rf.wr_data = 32'h0000_0005;
      rf.wr_en   = 1'b1;
      #1;
      chk("pre_rst_r9", rf.rd0_data, 32'h0000_0077);
      chk("pre_rst_r5", rf.rd1_data, 32'hDEAD_BEEF);
      tick();
      reset    = 1'b0;
      rf.wr_en = 1'b0;
      #1;
      chk("rstpri_r9", rf.rd0_data, 32'h0);
      chk("rstpri_r5", rf.rd1_data, 32'h0);
      rd(5'd7, 5'd12);
      chk("rstpri_r7", rf.rd0_data, 32'h0);
      chk("rstpri_r12", rf.rd1_data, 32'h0);

      // Storage works again after the mid-run reset.
      wr(5'd31, 32'hCAFE_F00D);
      rd(5'd31, 5'd30);
      chk("post_rst_r31", rf.rd0_data, 32'hCAFE_F00D);
      chk("post_rst_r30", rf.rd1_data, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 32, register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, register-select width; register count is 2**ADDR_W, so 32 by default.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_num  input  ADDR_W  write register select.
REQ-006 wr_data  input  DATA_W  write data.
REQ-007 wr_en  input  1  write enable, active-high.
REQ-008 rd0_num  input  ADDR_W  read port 0 register select.
REQ-009 rd0_data  output  DATA_W  read port 0 data.
REQ-010 rd1_num  input  ADDR_W  read port 1 register select.
REQ-011 rd1_data  output  DATA_W  read port 1 data.

Function
REQ-012 The block SHALL hold 2**ADDR_W registers of DATA_W bits each, registers 1..2**ADDR_W-1 being storage.
REQ-013 Register 0 SHALL always read as 0; writes to it SHALL be discarded.
REQ-014 On a rising clk edge with reset=0, wr_en=1 and wr_num!=0, the block SHALL load wr_data into register wr_num.
REQ-015 With wr_en=0, no register SHALL change.
REQ-016 rd0_data SHALL be combinational from rd0_num and register contents, with zero clock latency; rd1_data likewise from rd1_num.
REQ-017 Both read ports SHALL be independent: same or different selects in any cycle, including both equal to wr_num.
REQ-018 A write SHALL be visible on both read ports in the cycle after its clock edge.
REQ-019 Same-cycle read of the register being written SHALL follow REQ-028/REQ-029.
REQ-020 Outputs SHALL never be X/Z after the first reset has been applied.

Reset
REQ-021 While reset=1 at a rising clk edge, every register SHALL be cleared to 0.
REQ-022 A write requested in a reset cycle SHALL be ignored.
REQ-023 After reset, rd0_data and rd1_data SHALL read 0 for every select.
REQ-024 Reset asserted mid-operation SHALL discard all prior contents at that edge.
REQ-025 Reset SHALL take effect only on a clock edge.
REQ-026 Between reset edges, reads SHALL reflect current contents.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL select read-during-write behaviour.
REQ-028 With REGFILE_BYPASS_EN defined, when wr_en=1, reset=0, wr_num!=0 and rdX_num==wr_num, rdX_data SHALL equal wr_data combinationally in that same cycle.
REQ-029 Without REGFILE_BYPASS_EN, rdX_data SHALL return the pre-write stored value in that cycle and the new value from the next cycle.
REQ-030 In both builds, register 0 SHALL read 0 even when wr_num=0 and wr_en=1.

Verification
REQ-031 Reset check: assert reset for 1 clk, then sweep rd0_num and rd1_num over 0..31 -> all reads 0.
REQ-032 Write/read back: write 29<-0x80120000, then 31<-0x00000000, then 5<-0xDEADBEEF; read rd0_num=29, rd1_num=5 -> 0x80120000 and 0xDEADBEEF.
REQ-033 Register 0: write 0<-0xFFFFFFFF with wr_en=1; read rd0_num=0 -> 0x00000000.
REQ-034 Write enable: reg 7 holds 0x11111111; drive wr_num=7, wr_data=0x22222222, wr_en=0 for one edge -> reg 7 still reads 0x11111111.
REQ-035 Read during write: reg 3 holds 0xA; write 3<-0xB with rd0_num=rd1_num=3 in the same cycle -> reads 0xB that cycle with REGFILE_BYPASS_EN, 0xA without; 0xB next cycle in both builds.
REQ-036 Reset priority: reset=1 with wr_en=1, wr_num=9, wr_data=0x5 -> reg 9 reads 0 afterward.
